// File: rtl/game_pkg.sv
// Types and constants shared by the score keeper and its debris FIFO.
package game_pkg;

    typedef enum logic [1:0] {
        GAME_IDLE    = 2'd0,
        GAME_PLAYING = 2'd1,
        GAME_FAILED  = 2'd2
    } game_state_e;

    typedef enum logic [2:0] {
        DIR_UP         = 3'd0,
        DIR_DOWN       = 3'd1,
        DIR_LEFT       = 3'd2,
        DIR_RIGHT      = 3'd3,
        DIR_UP_LEFT    = 3'd4,
        DIR_UP_RIGHT   = 3'd5,
        DIR_DOWN_LEFT  = 3'd6,
        DIR_DOWN_RIGHT = 3'd7
    } direction_e;

    localparam int SCORE_W  = 20;
    localparam int COMBO_W  = 8;
    localparam int MULT_W   = 4;
    localparam int HEALTH_W = 7;
    localparam int X_W      = 12;
    localparam int Y_W      = 12;
    localparam int Z_W      = 14;
    localparam int ID_W     = 8;

    localparam int BASE_POINTS = 100;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;
    localparam logic [MULT_W-1:0]  MULT_MIN  = 4'd1;
    localparam logic [MULT_W-1:0]  MULT_MAX  = 4'd8;

    // Slices needed at each multiplier before it doubles.
    localparam logic [3:0] THRESH_X1 = 4'd2;
    localparam logic [3:0] THRESH_X2 = 4'd4;
    localparam logic [3:0] THRESH_X4 = 4'd8;

    function automatic logic [3:0] promote_threshold(input logic [MULT_W-1:0] mult);
        case (mult)
            4'd1:    return THRESH_X1;
            4'd2:    return THRESH_X2;
            4'd4:    return THRESH_X4;
            default: return 4'd0;
        endcase
    endfunction

    typedef struct packed {
        logic [X_W-1:0]  x;
        logic [Y_W-1:0]  y;
        logic [Z_W-1:0]  z;
        logic            color;
        direction_e      direction;
        logic [ID_W-1:0] id;
    } debris_t;

    localparam int DEBRIS_W = $bits(debris_t);

endpackage

// File: rtl/debris_fifo.sv
// First-word-fall-through FIFO: the head entry is always on o_data while o_valid is high.
module debris_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_full,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_valid   = (r_count != '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_pop     = o_valid && i_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = i_push && (!o_full || w_pop);

    // NOTE: storage is deliberately not reset; r_count alone says which slots hold data.
    always_ff @(posedge clk_in) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // NOTE: non-blocking assignments so every register here sees pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Game bookkeeping: score, combo, multiplier and health driven by slice/miss/hit events,
// plus a queue of sliced blocks handed to the debris renderer.
module score_keeper
    import game_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int HEALTH_INIT  = 50,
    parameter int HEALTH_MAX   = 100,
    parameter int MISS_PENALTY = 10,
    parameter int HIT_PENALTY  = 15
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        block_sliced,
    input  logic [11:0] block_x_in,
    input  logic [11:0] block_y_in,
    input  logic [13:0] block_z_in,
    input  logic        block_color_in,
    input  logic [2:0]  block_direction_in,
    input  logic [7:0]  block_ID_in,
    input  logic        block_missed,
    input  logic [7:0]  missed_ID_in,
    input  logic        player_hit_by_obstacle,
    output logic [1:0]  game_state,
    output logic [19:0] score,
    output logic [7:0]  combo,
    output logic [3:0]  multiplier,
    output logic [6:0]  health,
    output logic        debris_valid,
    input  logic        debris_ready,
    output logic [11:0] debris_x,
    output logic [11:0] debris_y,
    output logic [13:0] debris_z,
    output logic        debris_color,
    output logic [2:0]  debris_direction,
    output logic [7:0]  debris_ID,
    output logic        debris_overflow
);

    game_state_e          r_state;
    game_state_e          w_state_next;
    logic [SCORE_W-1:0]   r_score;
    logic [SCORE_W-1:0]   w_score_next;
    logic [COMBO_W-1:0]   r_combo;
    logic [COMBO_W-1:0]   w_combo_next;
    logic [MULT_W-1:0]    r_mult;
    logic [MULT_W-1:0]    w_mult_next;
    logic [3:0]           r_progress;
    logic [3:0]           w_progress_next;
    logic [3:0]           w_progress_inc;
    logic [HEALTH_W-1:0]  r_health;
    logic [HEALTH_W-1:0]  w_health_next;
    logic [ID_W-1:0]      r_last_missed_id;
    logic                 r_hit_prev;
    logic                 r_overflow;

    logic                 w_playing;
    logic                 w_start;
    logic                 w_slice;
    logic                 w_miss;
    logic                 w_hit;
    logic                 w_penalty;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_valid;
    logic [SCORE_W:0]     w_score_sum;
    logic [HEALTH_W:0]    w_health_up;
    logic [HEALTH_W:0]    w_penalty_total;
    logic [HEALTH_W:0]    w_health_net;
    debris_t              w_push_data;
    debris_t              w_pop_data;
    logic [DEBRIS_W-1:0]  w_pop_bits;

    assign w_playing = (r_state == GAME_PLAYING);
    assign w_start   = start_in && !w_playing;
    assign w_slice   = w_playing && block_sliced;
    assign w_miss    = w_playing && block_missed && (missed_ID_in != r_last_missed_id);
    assign w_hit     = w_playing && player_hit_by_obstacle && !r_hit_prev;
    assign w_penalty = w_miss || w_hit;
    assign w_pop     = w_fifo_valid && debris_ready;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= GAME_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through a combinational block can infer a latch.
        w_state_next = r_state;
        case (r_state)
            GAME_IDLE,
            GAME_FAILED:  if (start_in) w_state_next = GAME_PLAYING;
            GAME_PLAYING: if (w_health_next == '0) w_state_next = GAME_FAILED;
            default:      w_state_next = GAME_IDLE;
        endcase
    end

    always_comb begin
        w_score_next    = r_score;
        w_combo_next    = r_combo;
        w_mult_next     = r_mult;
        w_progress_next = r_progress;
        w_progress_inc  = r_progress + 4'd1;
        // Score always uses the multiplier in force before this cycle's events.
        w_score_sum     = {1'b0, r_score} + (21'(BASE_POINTS) * 21'(r_mult));

        if (w_slice) begin
            w_score_next = w_score_sum[SCORE_W] ? SCORE_MAX : w_score_sum[SCORE_W-1:0];
        end

        if (w_penalty) begin
            w_combo_next    = '0;
            w_progress_next = '0;
            w_mult_next     = (r_mult > MULT_MIN) ? (r_mult >> 1) : MULT_MIN;
        end else if (w_slice) begin
            if (r_combo != COMBO_MAX) begin
                w_combo_next = r_combo + 1'b1;
            end
            if (r_mult != MULT_MAX) begin
                if (w_progress_inc >= promote_threshold(r_mult)) begin
                    w_mult_next     = r_mult << 1;
                    w_progress_next = '0;
                end else begin
                    w_progress_next = w_progress_inc;
                end
            end
        end

        // Net health change is +1 for a slice minus any penalties, then clamped to [0, HEALTH_MAX].
        w_health_up     = {1'b0, r_health} + {{HEALTH_W{1'b0}}, w_slice};
        w_penalty_total = (w_miss ? 8'(MISS_PENALTY) : 8'd0) + (w_hit ? 8'(HIT_PENALTY) : 8'd0);
        if (w_health_up <= w_penalty_total) begin
            w_health_net = '0;
        end else begin
            w_health_net = w_health_up - w_penalty_total;
        end
        if (w_health_net > 8'(HEALTH_MAX)) begin
            w_health_next = 7'(HEALTH_MAX);
        end else begin
            w_health_next = w_health_net[HEALTH_W-1:0];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_score          <= '0;
            r_combo          <= '0;
            r_mult           <= MULT_MIN;
            r_progress       <= '0;
            r_health         <= '0;
            r_last_missed_id <= '0;
        end else if (w_start) begin
            r_score          <= '0;
            r_combo          <= '0;
            r_mult           <= MULT_MIN;
            r_progress       <= '0;
            r_health         <= 7'(HEALTH_INIT);
            r_last_missed_id <= '0;
        end else if (w_playing) begin
            r_score    <= w_score_next;
            r_combo    <= w_combo_next;
            r_mult     <= w_mult_next;
            r_progress <= w_progress_next;
            r_health   <= w_health_next;
            if (w_miss) begin
                r_last_missed_id <= missed_ID_in;
            end
        end
    end

    // The obstacle level is tracked in every state so a hit held across start is not a fresh edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_hit_prev <= 1'b0;
        end else begin
            r_hit_prev <= player_hit_by_obstacle;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || w_start) begin
            r_overflow <= 1'b0;
        end else if (w_slice && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    always_comb begin
        w_push_data           = '0;
        w_push_data.x         = block_x_in;
        w_push_data.y         = block_y_in;
        w_push_data.z         = block_z_in;
        w_push_data.color     = block_color_in;
        w_push_data.direction = direction_e'(block_direction_in);
        w_push_data.id        = block_ID_in;
    end

    debris_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DEBRIS_W)
    ) u_debris_fifo (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .i_flush     (w_start),
        .i_push      (w_slice),
        .i_push_data (w_push_data),
        .o_full      (w_fifo_full),
        .o_valid     (w_fifo_valid),
        .i_ready     (debris_ready),
        .o_data      (w_pop_bits)
    );

    assign w_pop_data = debris_t'(w_pop_bits);

    assign game_state       = r_state;
    assign score            = r_score;
    assign combo            = r_combo;
    assign multiplier       = r_mult;
    assign health           = r_health;
    assign debris_valid     = w_fifo_valid;
    assign debris_x         = w_pop_data.x;
    assign debris_y         = w_pop_data.y;
    assign debris_z         = w_pop_data.z;
    assign debris_color     = w_pop_data.color;
    assign debris_direction = w_pop_data.direction;
    assign debris_ID        = w_pop_data.id;
    assign debris_overflow  = r_overflow;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a rule-level model predicts every cycle, a monitor compares.
`timescale 1ns/1ps
module tb_score_keeper;

    localparam int DEPTH  = 4;
    localparam int H_INIT = 50;
    localparam int H_MAX  = 100;
    localparam int MISS_P = 10;
    localparam int HIT_P  = 15;
    localparam int S_MAX  = (1 << 20) - 1;

    logic        clk_in = 1'b0;
    logic        rst_in, start_in, block_sliced, block_color_in, block_missed;
    logic        player_hit_by_obstacle, debris_ready;
    logic [11:0] block_x_in, block_y_in;
    logic [13:0] block_z_in;
    logic [2:0]  block_direction_in;
    logic [7:0]  block_ID_in, missed_ID_in;
    logic [1:0]  game_state;
    logic [19:0] score;
    logic [7:0]  combo;
    logic [3:0]  multiplier;
    logic [6:0]  health;
    logic        debris_valid, debris_color, debris_overflow;
    logic [11:0] debris_x, debris_y;
    logic [13:0] debris_z;
    logic [2:0]  debris_direction;
    logic [7:0]  debris_ID;

    score_keeper #(
        .FIFO_DEPTH(DEPTH), .HEALTH_INIT(H_INIT), .HEALTH_MAX(H_MAX),
        .MISS_PENALTY(MISS_P), .HIT_PENALTY(HIT_P)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .block_sliced(block_sliced),
        .block_x_in(block_x_in), .block_y_in(block_y_in), .block_z_in(block_z_in),
        .block_color_in(block_color_in), .block_direction_in(block_direction_in),
        .block_ID_in(block_ID_in), .block_missed(block_missed), .missed_ID_in(missed_ID_in),
        .player_hit_by_obstacle(player_hit_by_obstacle), .game_state(game_state),
        .score(score), .combo(combo), .multiplier(multiplier), .health(health),
        .debris_valid(debris_valid), .debris_ready(debris_ready), .debris_x(debris_x),
        .debris_y(debris_y), .debris_z(debris_z), .debris_color(debris_color),
        .debris_direction(debris_direction), .debris_ID(debris_ID),
        .debris_overflow(debris_overflow)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {int x; int y; int z; int color; int dir; int id;} blk_t;
    typedef struct {int state; int score; int combo; int mult; int health; int valid; int ovf; blk_t head;} snap_t;

    snap_t exp_q[$];
    blk_t  m_fifo[$];
    int    m_state, m_score, m_combo, m_mult, m_prog, m_health, m_last_id, m_prev_hit, m_ovf;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    next_id  = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: applies the game rules to the inputs sampled at the coming edge.
    task automatic model_step();
        blk_t b;
        int   sl, mi, hi, pop, full;
        if (rst_in) begin
            m_state = 0; m_score = 0; m_combo = 0; m_mult = 1; m_prog = 0;
            m_health = 0; m_last_id = 0; m_prev_hit = 0; m_ovf = 0;
            m_fifo.delete();
            return;
        end
        pop  = (m_fifo.size() > 0 && debris_ready) ? 1 : 0;
        full = (m_fifo.size() == DEPTH) ? 1 : 0;
        if (m_state != 1) begin
            if (start_in) begin
                m_state = 1; m_score = 0; m_combo = 0; m_mult = 1; m_prog = 0;
                m_health = H_INIT; m_last_id = 0; m_ovf = 0;
                m_fifo.delete();
            end else if (pop != 0) begin
                void'(m_fifo.pop_front());
            end
        end else begin
            sl = block_sliced ? 1 : 0;
            mi = (block_missed && int'(missed_ID_in) != m_last_id) ? 1 : 0;
            hi = (player_hit_by_obstacle && m_prev_hit == 0) ? 1 : 0;
            if (mi != 0) m_last_id = int'(missed_ID_in);
            if (sl != 0) m_score = (m_score + 100 * m_mult > S_MAX) ? S_MAX : m_score + 100 * m_mult;
            if (mi != 0 || hi != 0) begin
                m_combo = 0; m_prog = 0;
                m_mult  = (m_mult > 1) ? m_mult / 2 : 1;
            end else if (sl != 0) begin
                if (m_combo < 255) m_combo++;
                if (m_mult < 8) begin
                    m_prog++;
                    if (m_prog == 2 * m_mult) begin
                        m_mult = m_mult * 2;
                        m_prog = 0;
                    end
                end
            end
            m_health = m_health + sl - mi * MISS_P - hi * HIT_P;
            if (m_health < 0) m_health = 0;
            if (m_health > H_MAX) m_health = H_MAX;
            if (m_health == 0) m_state = 2;
            if (pop != 0) void'(m_fifo.pop_front());
            if (sl != 0) begin
                if (full == 0 || pop != 0) begin
                    b.x = int'(block_x_in); b.y = int'(block_y_in); b.z = int'(block_z_in);
                    b.color = int'(block_color_in); b.dir = int'(block_direction_in);
                    b.id = int'(block_ID_in);
                    m_fifo.push_back(b);
                end else begin
                    m_ovf = 1;
                end
            end
        end
        m_prev_hit = player_hit_by_obstacle ? 1 : 0;
    endtask

    task automatic step(input bit rst, input bit start, input bit slice, input bit missed,
                        input int mid, input bit hit, input bit ready);
        snap_t s;
        @(negedge clk_in);
        rst_in = rst; start_in = start; block_sliced = slice; block_missed = missed;
        missed_ID_in = 8'(mid); player_hit_by_obstacle = hit; debris_ready = ready;
        block_x_in = 12'($urandom); block_y_in = 12'($urandom); block_z_in = 14'($urandom);
        block_color_in = 1'($urandom); block_direction_in = 3'($urandom);
        block_ID_in = 8'(next_id);
        if (slice) next_id = (next_id + 1) % 256;
        model_step();
        s.state = m_state; s.score = m_score; s.combo = m_combo; s.mult = m_mult;
        s.health = m_health; s.ovf = m_ovf; s.valid = (m_fifo.size() > 0) ? 1 : 0;
        s.head = '{0, 0, 0, 0, 0, 0};
        if (m_fifo.size() > 0) s.head = m_fifo[0];
        exp_q.push_back(s);
    endtask

    task automatic sample();
        @(posedge clk_in);
        #2;
    endtask

    // Monitor: one expected snapshot per clock edge, compared just after the edge.
    initial begin : monitor
        snap_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("game_state", game_state, e.state);
                check("score", score, e.score);
                check("combo", combo, e.combo);
                check("multiplier", multiplier, e.mult);
                check("health", health, e.health);
                check("debris_valid", debris_valid, e.valid);
                check("debris_overflow", debris_overflow, e.ovf);
                if (e.valid != 0) begin
                    check("debris_ID", debris_ID, e.head.id);
                    check("debris_x", debris_x, e.head.x);
                    check("debris_y", debris_y, e.head.y);
                    check("debris_z", debris_z, e.head.z);
                    check("debris_color", debris_color, e.head.color);
                    check("debris_direction", debris_direction, e.head.dir);
                end
            end
        end
    end

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int base_id;
        int saved_score;
        rst_in = 1'b1; start_in = 1'b0; block_sliced = 1'b0; block_missed = 1'b0;
        missed_ID_in = '0; player_hit_by_obstacle = 1'b0; debris_ready = 1'b0;
        block_x_in = '0; block_y_in = '0; block_z_in = '0; block_color_in = 1'b0;
        block_direction_in = '0; block_ID_in = '0;

        // Reset state.
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        sample();
        check("reset_state", game_state, 0);
        check("reset_health", health, 0);
        check("reset_mult", multiplier, 1);
        check("reset_valid", debris_valid, 0);

        // Start, two slices, then three more into a FIFO that is never drained.
        step(0, 1, 0, 0, 0, 0, 0);
        base_id = next_id;
        step(0, 0, 1, 0, 0, 0, 0);
        sample();
        check("first_slice_score", score, 100);
        step(0, 0, 1, 0, 0, 0, 0);
        sample();
        check("second_slice_score", score, 200);
        check("second_slice_mult", multiplier, 2);
        check("second_slice_combo", combo, 2);
        check("second_slice_health", health, 52);
        repeat (3) step(0, 0, 1, 0, 0, 0, 0);
        sample();
        check("fifo_overflow", debris_overflow, 1);
        check("fifo_full_valid", debris_valid, 1);
        for (int k = 0; k < 4; k++) begin
            check("debris_order", debris_ID, (base_id + k) % 256);
            step(0, 0, 0, 0, 0, 0, 1);
            sample();
        end
        check("fifo_drained_valid", debris_valid, 0);

        // One miss per block ID, however long it is presented.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        repeat (5) step(0, 0, 0, 1, 7, 0, 0);
        sample();
        check("miss_once_health", health, 40);
        check("miss_once_combo", combo, 0);
        step(0, 0, 0, 1, 8, 0, 0);
        step(0, 0, 0, 0, 8, 0, 0);
        sample();
        check("second_miss_health", health, 30);

        // Climb to multiplier 8, then a held obstacle counts once.
        repeat (14) step(0, 0, 1, 0, 0, 0, 1);
        sample();
        check("mult_eight", multiplier, 8);
        check("health_after_climb", health, 44);
        repeat (3) step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        sample();
        check("hit_halves_mult", multiplier, 4);
        check("hit_once_health", health, 29);

        // Drive health to exactly 10, then a miss ends the game and freezes the score.
        step(0, 0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 1, 10, 0, 1);
        step(0, 0, 0, 1, 11, 0, 1);
        sample();
        check("health_ten", health, 10);
        step(0, 0, 0, 1, 12, 0, 1);
        sample();
        check("fail_health", health, 0);
        check("fail_state", game_state, 2);
        saved_score = m_score;
        step(0, 0, 1, 0, 0, 0, 1);
        sample();
        check("frozen_score", score, saved_score);
        check("frozen_state", game_state, 2);

        // Long run from FAILED: score, combo and health all reach their ceilings.
        step(0, 1, 0, 0, 0, 0, 1);
        repeat (1320) step(0, 0, 1, 0, 0, 0, 1);
        sample();
        check("score_saturated", score, S_MAX);
        check("combo_saturated", combo, 255);
        check("health_capped", health, H_MAX);
        check("mult_capped", multiplier, 8);

        // Randomized traffic, including restarts and the odd reset.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 15,
                 int'($urandom_range(0, 3)), $urandom_range(0, 99) < 10, $urandom_range(0, 1) == 1);
        end

        // Reset in mid-game with debris queued.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0, 0, 0);
        sample();
        check("pre_reset_valid", debris_valid, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        sample();
        check("midgame_rst_state", game_state, 0);
        check("midgame_rst_score", score, 0);
        check("midgame_rst_combo", combo, 0);
        check("midgame_rst_mult", multiplier, 1);
        check("midgame_rst_health", health, 0);
        check("midgame_rst_valid", debris_valid, 0);
        check("midgame_rst_overflow", debris_overflow, 0);

        repeat (3) @(posedge clk_in);
        #2;
        if (exp_q.size() != 0) check("scoreboard_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
